// File: rtl/cla_serial_seq.sv
// cla_serial_seq: multi-cycle WIDTH-bit add/subtract built on one shared 4-bit
// carry-lookahead slice, processing one nibble per cycle LSB first, with
// optional signed saturation and result flags.
module cla_serial_seq #(
    parameter  int WIDTH   = 16,
    localparam int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovfl,
    output logic             zero,
    output logic             neg
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [1:0]      op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;

    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [3:0]      g;
    logic [3:0]      p;
    logic [3:0]      c;
    logic [3:0]      slice_sum;
    logic            slice_cout;

    logic             raw_ovfl;
    logic             sat;
    logic [WIDTH-1:0] final_result;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and issue-side handshake
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) next_state = RUN;
            end
            RUN: begin
                if (cnt == LAST) next_state = FIN;
            end
            FIN: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // 4-bit carry-lookahead slice on the nibble selected by cnt
    always_comb begin
        a_nib = a_reg[{cnt, 2'b00} +: 4];
        b_nib = b_reg[{cnt, 2'b00} +: 4];
        g     = a_nib & b_nib;
        p     = a_nib ^ b_nib;
        c[0]  = carry;
        c[1]  = g[0] | (p[0] & carry);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry);
        slice_cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0])
                   | (p[3] & p[2] & p[1] & p[0] & carry);
        slice_sum = p ^ c;
    end

    // Overflow and saturation on the assembled raw sum (b_reg is already inverted for SUB)
    always_comb begin
        raw_ovfl = (a_reg[MSB] == b_reg[MSB]) && (sum_reg[MSB] != a_reg[MSB]);
        sat      = op_reg[1] && raw_ovfl;
        if (sat) begin
            final_result = a_reg[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            final_result = sum_reg;
        end
    end

    // Operand capture, nibble-serial accumulation and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            carry   <= 1'b0;
            op_reg  <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovfl    <= 1'b0;
            zero    <= 1'b0;
            neg     <= 1'b0;
        end else begin
            done <= (state == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= op[0] ? ~b : b;
                        op_reg <= op;
                        carry  <= op[0];
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    sum_reg[{cnt, 2'b00} +: 4] <= slice_sum;
                    carry                      <= slice_cout;
                    cnt                        <= cnt + 1'b1;
                end
                FIN: begin
                    result <= final_result;
                    cout   <= carry;
                    ovfl   <= raw_ovfl;
                    zero   <= (final_result == '0);
                    neg    <= final_result[MSB];
                end
                default: ;
            endcase
        end
    end

endmodule
